// File: rtl/hilo_div_ctrl.sv
// rtl/hilo_div_ctrl.sv - HI/LO register owner, single-cycle multiply, iterative-divider sequencer
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   op_valid, op      EX-stage instruction: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                     5 MTHI, 6 MTLO, 7 reserved (none)
//   rs_data, rt_data  rs / rt operands
//   flush             kills the EX instruction and any in-flight divide
//   div_start         divider Start, held high for the whole divide
//   div_signed        divider Signed, registered with the operands
//   div_a, div_b      registered dividend / divisor
//   div_annul         divider Annul, tied low (flushes are drained instead)
//   div_result        divider {remainder, quotient}, valid with div_ready
//   div_ready         divider done pulse
//   stall             freeze IF/ID/EX
//   hi, lo            architectural HI/LO registers

module hilo_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        issue;
    logic        is_hilo_op;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] prod;
    logic [31:0] hi_nx;
    logic [31:0] lo_nx;
    logic        start_nx;
    logic        div_load;

    assign issue      = op_valid & ~flush;
    assign is_hilo_op = (op != OP_NONE) && (op != OP_RSVD);

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};
    assign prod   = (op == OP_MULT) ? prod_s : prod_u;

    assign div_annul = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        hi_nx    = hi;
        lo_nx    = lo;
        start_nx = div_start;
        div_load = 1'b0;
        case (state)
            IDLE: begin
                start_nx = 1'b0;
                if (issue) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            hi_nx = prod[63:32];
                            lo_nx = prod[31:0];
                        end
                        OP_DIV, OP_DIVU: begin
                            stall    = 1'b1;
                            div_load = 1'b1;
                            start_nx = 1'b1;
                            state_nx = BUSY;
                        end
                        OP_MTHI: hi_nx = rs_data;
                        OP_MTLO: lo_nx = rs_data;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // The divide instruction retires in the div_ready cycle.
                stall = ~div_ready;
                if (flush) begin
                    // Flush beats a coincident div_ready: the result is dropped.
                    if (div_ready) begin
                        start_nx = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        state_nx = DRAIN;
                    end
                end else if (div_ready) begin
                    hi_nx    = div_result[63:32];
                    lo_nx    = div_result[31:0];
                    start_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            DRAIN: begin
                // Keep Start high until the divider finishes; hold any new HI/LO
                // user so it cannot overtake, and consume it only once back in IDLE.
                stall = op_valid & is_hilo_op;
                if (div_ready) begin
                    start_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                start_nx = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi         <= 32'd0;
            lo         <= 32'd0;
            div_start  <= 1'b0;
            div_signed <= 1'b0;
            div_a      <= 32'd0;
            div_b      <= 32'd0;
        end else begin
            hi        <= hi_nx;
            lo        <= lo_nx;
            div_start <= start_nx;
            if (div_load) begin
                div_a      <= rs_data;
                div_b      <= rt_data;
                div_signed <= (op == OP_DIV);
            end
        end
    end

endmodule
